// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage:
// FSM states, access-size decode and the funct3 load/store encodings.
package mem_stage_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TIMEOUT_DEFAULT = 255;

    // Unsigned variants only exist for loads; any unlisted code is a word access.
    function automatic size_t access_size(input logic [2:0] funct3, input logic is_store);
        case (funct3)
            F3_B:    return SZ_BYTE;
            F3_H:    return SZ_HALF;
            F3_W:    return SZ_WORD;
            F3_BU:   return is_store ? SZ_WORD : SZ_BYTE;
            F3_HU:   return is_store ? SZ_WORD : SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/halfword lane of a bus read word and
// sign- or zero-extends it to the datapath width.
module load_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            byte_off,
    input  size_t                 size,
    input  logic                  is_unsigned,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // NOTE: every variable assigned in always_comb gets a default first so no path infers a latch.
    always_comb begin
        byte_lane = rdata[8*byte_off +: 8];
        half_lane = byte_off[1] ? rdata[16 +: 16] : rdata[0 +: 16];
        data      = rdata;
        case (size)
            SZ_BYTE: data = {{(DATA_WIDTH-8){byte_lane[7] & ~is_unsigned}}, byte_lane};
            SZ_HALF: data = {{(DATA_WIDTH-16){half_lane[15] & ~is_unsigned}}, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: E-to-M register, bus handshake FSM with timeout,
// misalignment detection, store lane steering and load alignment.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH             = 32,
    parameter int REG_FILE_ADDRESS_WIDTH = 5,
    parameter int TIMEOUT                = TIMEOUT_DEFAULT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              RegWriteE,
    input  logic                              MemWriteE,
    input  logic                              MemReadE,
    input  logic [1:0]                        ResultSrcE,
    input  logic [2:0]                        Funct3E,
    input  logic [DATA_WIDTH-1:0]             ALUResultE,
    input  logic [DATA_WIDTH-1:0]             WriteDataE,
    input  logic [DATA_WIDTH-1:0]             PCPlus4E,
    input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdE,
    output logic                              RegWriteM,
    output logic [1:0]                        ResultSrcM,
    output logic [REG_FILE_ADDRESS_WIDTH-1:0] RdM,
    output logic [DATA_WIDTH-1:0]             ALUResultM,
    output logic [DATA_WIDTH-1:0]             PCPlus4M,
    output logic [DATA_WIDTH-1:0]             ReadDataM,
    output logic                              StallM,
    output logic                              MisalignM,
    output logic                              mem_err,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [DATA_WIDTH-1:0]             mem_addr,
    output logic [3:0]                        mem_wstrb,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    input  logic                              mem_ready,
    input  logic [DATA_WIDTH-1:0]             mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic                              reg_write_q, mem_write_q, mem_read_q;
    logic [1:0]                        result_src_q;
    logic [2:0]                        funct3_q;
    logic [DATA_WIDTH-1:0]             alu_q, wdata_q, pc4_q;
    logic [REG_FILE_ADDRESS_WIDTH-1:0] rd_q;

    // NOTE: registered state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            result_src_q <= '0;
            funct3_q     <= '0;
            alu_q        <= '0;
            wdata_q      <= '0;
            pc4_q        <= '0;
            rd_q         <= '0;
        end else if (!StallM) begin
            reg_write_q  <= RegWriteE;
            mem_write_q  <= MemWriteE;
            mem_read_q   <= MemReadE;
            result_src_q <= ResultSrcE;
            funct3_q     <= Funct3E;
            alu_q        <= ALUResultE;
            wdata_q      <= WriteDataE;
            pc4_q        <= PCPlus4E;
            rd_q         <= RdE;
        end
    end

    // A read+write combination is treated as a store.
    logic       is_mem, is_store, is_load, misaligned, access;
    size_t      size;
    logic [1:0] byte_off;

    assign is_store   = mem_write_q;
    assign is_mem     = mem_write_q | mem_read_q;
    assign is_load    = mem_read_q & ~mem_write_q;
    assign size       = access_size(funct3_q, is_store);
    assign byte_off   = alu_q[1:0];
    assign misaligned = is_mem & (((size == SZ_HALF) & byte_off[0]) |
                                  ((size == SZ_WORD) & (|byte_off)));
    assign access     = is_mem & ~misaligned;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q, timed_out, abort;

    // Abort on the TIMEOUT-th cycle spent in WAIT; a same-cycle mem_ready still wins.
    assign timed_out = (wait_cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        StallM  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    mem_req = 1'b1;
                    if (!mem_ready) begin
                        StallM  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    mem_req = 1'b1;
                    state_d = ST_IDLE;
                end else if (timed_out) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    mem_req = 1'b1;
                    StallM  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= (state_q == ST_WAIT && state_d == ST_WAIT) ? wait_cnt_q + 1'b1 : '0;
            if (abort) err_q <= 1'b1;
        end
    end

    logic [3:0]            strobe;
    logic [DATA_WIDTH-1:0] wdata_lane;

    always_comb begin
        strobe     = 4'b1111;
        wdata_lane = wdata_q;
        case (size)
            SZ_BYTE: begin
                strobe     = 4'b0001 << byte_off;
                wdata_lane = {4{wdata_q[7:0]}};
            end
            SZ_HALF: begin
                strobe     = 4'b0011 << byte_off;
                wdata_lane = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    logic [DATA_WIDTH-1:0] load_data;

    load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
        .rdata       (mem_rdata),
        .byte_off    (byte_off),
        .size        (size),
        .is_unsigned (funct3_q[2]),
        .data        (load_data)
    );

    assign mem_we     = mem_req & is_store;
    assign mem_addr   = {alu_q[DATA_WIDTH-1:2], 2'b00};
    assign mem_wstrb  = mem_we ? strobe : 4'b0000;
    assign mem_wdata  = wdata_lane;
    assign ReadDataM  = (is_load & access & ~abort) ? load_data : '0;
    assign RegWriteM  = reg_write_q & ~misaligned & ~abort;
    assign MisalignM  = misaligned;
    assign mem_err    = err_q | abort;
    assign ResultSrcM = result_src_q;
    assign RdM        = rd_q;
    assign ALUResultM = alu_q;
    assign PCPlus4M   = pc4_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus random traffic
// compared every cycle against a per-instruction behavioural model.
module tb_mem_stage;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int TO = 12;
    localparam int NEVER = 1000;

    logic          clk, rst;
    logic          RegWriteE, MemWriteE, MemReadE;
    logic [1:0]    ResultSrcE;
    logic [2:0]    Funct3E;
    logic [DW-1:0] ALUResultE, WriteDataE, PCPlus4E;
    logic [RW-1:0] RdE;
    logic          RegWriteM;
    logic [1:0]    ResultSrcM;
    logic [RW-1:0] RdM;
    logic [DW-1:0] ALUResultM, PCPlus4M, ReadDataM;
    logic          StallM, MisalignM, mem_err, mem_req, mem_we, mem_ready;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]    mem_wstrb;

    mem_stage #(.DATA_WIDTH(DW), .REG_FILE_ADDRESS_WIDTH(RW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemReadE(MemReadE),
        .ResultSrcE(ResultSrcE), .Funct3E(Funct3E), .ALUResultE(ALUResultE),
        .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .RdE(RdE),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
        .ALUResultM(ALUResultM), .PCPlus4M(PCPlus4M), .ReadDataM(ReadDataM),
        .StallM(StallM), .MisalignM(MisalignM), .mem_err(mem_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One instruction plus the bus behaviour it will see while in M.
    typedef struct {
        bit        rw, mw, mr;
        bit [1:0]  rs;
        bit [2:0]  f3;
        bit [31:0] alu, wd, pc4;
        bit [4:0]  rd;
        int        ready_at;
        bit [31:0] rdata;
    } instr_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Model: the instruction sitting in M, how many cycles it has been there, sticky error.
    instr_t m;
    int     m_cyc;
    bit     m_err;
    bit     exp_stall_q;

    logic        last_req, last_stall, last_rw, last_mis, last_err, last_we;
    logic [3:0]  last_strb;
    logic [31:0] last_addr, last_wdata, last_rdata, last_alu;

    function automatic instr_t bubble();
        instr_t b;
        b.rw = 0; b.mw = 0; b.mr = 0; b.rs = 0; b.f3 = 0;
        b.alu = 0; b.wd = 0; b.pc4 = 0; b.rd = 0; b.ready_at = 0; b.rdata = 0;
        return b;
    endfunction

    function automatic int bytes_of(input bit [2:0] f3, input bit store);
        case (f3)
            3'b000:  return 1;
            3'b001:  return 2;
            3'b100:  return store ? 4 : 1;
            3'b101:  return store ? 4 : 2;
            default: return 4;
        endcase
    endfunction

    task automatic step(input instr_t e, input bit do_rst);
        bit        is_mem, store, mis, access, ready, abort, req, sgn;
        int        nb, off;
        bit [31:0] exp_rd, exp_strb, exp_wd;
        @(negedge clk);
        RegWriteE  = e.rw;  MemWriteE = e.mw; MemReadE = e.mr;
        ResultSrcE = e.rs;  Funct3E   = e.f3; ALUResultE = e.alu;
        WriteDataE = e.wd;  PCPlus4E  = e.pc4; RdE = e.rd;
        rst        = do_rst;
        ready      = (m_cyc == m.ready_at);
        mem_ready  = ready;
        mem_rdata  = m.rdata;
        #1;
        is_mem = m.mw || m.mr;
        store  = m.mw;
        nb     = bytes_of(m.f3, store);
        off    = int'(m.alu % 4);
        mis    = is_mem && ((m.alu % nb) != 0);
        access = is_mem && !mis;
        abort  = access && !ready && (m_cyc == TO);
        req    = access && !abort;
        exp_stall_q = access && !ready && !abort;

        check("stall", StallM, exp_stall_q);
        check("mem_req", mem_req, req);
        check("misalign", MisalignM, mis);
        check("regwrite", RegWriteM, m.rw && !mis && !abort);
        check("mem_err", mem_err, m_err || abort);
        check("rd", RdM, m.rd);
        check("resultsrc", ResultSrcM, m.rs);
        check("alu", ALUResultM, m.alu);
        check("pc4", PCPlus4M, m.pc4);
        if (req) begin
            check("mem_we", mem_we, store);
            check("mem_addr", mem_addr, m.alu & ~32'h3);
            if (store) begin
                exp_strb = ((32'd1 << nb) - 1) << off;
                exp_wd   = (nb == 1) ? (m.wd & 32'hFF) * 32'h01010101 :
                           (nb == 2) ? (m.wd & 32'hFFFF) * 32'h00010001 : m.wd;
                check("mem_wstrb", mem_wstrb, exp_strb);
                check("mem_wdata", mem_wdata, exp_wd);
            end
        end
        if (!store && m.mr && access && (ready || abort)) begin
            sgn    = (m.f3 == 3'b000) || (m.f3 == 3'b001);
            exp_rd = m.rdata >> (8 * off);
            if (nb == 1) begin
                exp_rd &= 32'hFF;
                if (sgn && exp_rd >= 32'h80) exp_rd |= 32'hFFFFFF00;
            end else if (nb == 2) begin
                exp_rd &= 32'hFFFF;
                if (sgn && exp_rd >= 32'h8000) exp_rd |= 32'hFFFF0000;
            end
            check("readdata", ReadDataM, abort ? 32'h0 : exp_rd);
        end

        last_req = mem_req;     last_stall = StallM;   last_rw = RegWriteM;
        last_mis = MisalignM;   last_err   = mem_err;  last_we = mem_we;
        last_strb = mem_wstrb;  last_addr  = mem_addr; last_wdata = mem_wdata;
        last_rdata = ReadDataM; last_alu   = ALUResultM;

        @(posedge clk);
        if (do_rst) begin
            m = bubble(); m_cyc = 0; m_err = 0; exp_stall_q = 0;
        end else begin
            m_err = m_err || abort;
            if (!exp_stall_q) begin
                m = e; m_cyc = 0;
            end else begin
                m_cyc++;
            end
        end
    endtask

    // Present e on the E side, holding it while M is stalled; n = cycles taken.
    task automatic issue(input instr_t e, output int n);
        n = 0;
        do begin
            step(e, 1'b0);
            n++;
        end while (exp_stall_q && n < TO + 8);
        if (exp_stall_q) check("issue bound", {31'b0, exp_stall_q}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t i;
        int     n;
        bit [2:0] f3_list [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

        rst = 1'b1;
        RegWriteE = 0; MemWriteE = 0; MemReadE = 0; ResultSrcE = 0; Funct3E = 0;
        ALUResultE = 0; WriteDataE = 0; PCPlus4E = 0; RdE = 0;
        mem_ready = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        m = bubble(); m_cyc = 0; m_err = 0; exp_stall_q = 0;

        step(bubble(), 1'b0);
        check("reset rdata", last_rdata, 32'h0);
        check("reset wstrb", last_strb, 4'h0);
        check("reset we", last_we, 1'b0);

        // SW 0x100 <- DEADBEEF, immediate ready
        i = bubble(); i.mw = 1; i.f3 = 3'b010; i.alu = 32'h100; i.wd = 32'hDEADBEEF;
        issue(i, n);
        issue(bubble(), n);
        check("sw cycles", n, 1);
        check("sw strb", last_strb, 4'hF);
        check("sw stall", last_stall, 1'b0);

        // LB 0x103, ready after 3 stalled cycles
        i = bubble(); i.mr = 1; i.rw = 1; i.f3 = 3'b000; i.alu = 32'h103;
        i.rdata = 32'h80000000; i.ready_at = 3;
        issue(i, n);
        issue(bubble(), n);
        check("lb cycles", n, 4);
        check("lb data", last_rdata, 32'hFFFFFF80);
        i.f3 = 3'b100;
        issue(i, n);
        issue(bubble(), n);
        check("lbu data", last_rdata, 32'h00000080);

        // SH 0x102 <- 0x1234
        i = bubble(); i.mw = 1; i.f3 = 3'b001; i.alu = 32'h102; i.wd = 32'h1234;
        issue(i, n);
        issue(bubble(), n);
        check("sh strb", last_strb, 4'hC);
        check("sh wdata", last_wdata, 32'h12341234);
        check("sh addr", last_addr, 32'h100);

        // LW 0x101 misaligned
        i = bubble(); i.mr = 1; i.rw = 1; i.f3 = 3'b010; i.alu = 32'h101;
        issue(i, n);
        issue(bubble(), n);
        check("lw mis cycles", n, 1);
        check("lw mis flag", last_mis, 1'b1);
        check("lw mis req", last_req, 1'b0);
        check("lw mis rw", last_rw, 1'b0);

        // LW with the bus never answering
        i = bubble(); i.mr = 1; i.rw = 1; i.f3 = 3'b010; i.alu = 32'h200;
        i.rdata = 32'hA5A5A5A5; i.ready_at = NEVER;
        issue(i, n);
        issue(bubble(), n);
        check("timeout cycles", n, TO + 1);
        check("timeout err", last_err, 1'b1);
        check("timeout stall", last_stall, 1'b0);
        check("timeout rw", last_rw, 1'b0);
        check("timeout rdata", last_rdata, 32'h0);

        // Reset on the second WAIT cycle
        issue(i, n);
        step(bubble(), 1'b0);
        step(bubble(), 1'b0);
        step(bubble(), 1'b1);
        step(bubble(), 1'b0);
        check("rst req", last_req, 1'b0);
        check("rst stall", last_stall, 1'b0);
        check("rst rw", last_rw, 1'b0);
        check("rst alu", last_alu, 32'h0);
        check("rst err", last_err, 1'b0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            i = bubble();
            i.rw  = 1'($urandom);
            i.rs  = 2'($urandom);
            i.rd  = 5'($urandom);
            i.alu = $urandom;
            i.wd  = $urandom;
            i.pc4 = $urandom;
            i.rdata = $urandom;
            i.f3  = f3_list[$urandom_range(0, 7)];
            if ($urandom_range(0, 3) != 0) {i.mw, i.mr} = 2'($urandom_range(1, 3));
            i.ready_at = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 4));
            if ($urandom_range(0, 49) == 0) step(bubble(), 1'b1);
            issue(i, n);
        end
        issue(bubble(), n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
